// File: rtl/cr16_alu_seq_if.sv
// Request/result bundle between the CR16 register-file read ports, the ALU and writeback.
// Requests are taken on I_VALID & O_READY; O_VALID is a one-cycle pulse per result (stretched while disabled).
interface cr16_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             I_ENABLE;
  logic             I_VALID;
  logic             O_READY;
  logic [3:0]       I_OPCODE;
  logic [WIDTH-1:0] I_A;
  logic [WIDTH-1:0] I_B;
  logic             O_VALID;
  logic [WIDTH-1:0] O_C;
  logic [4:0]       O_STATUS;
  logic             O_BUSY;

  modport master (
    output I_ENABLE, I_VALID, I_OPCODE, I_A, I_B,
    input  O_READY, O_VALID, O_C, O_STATUS, O_BUSY
  );

  modport slave (
    input  I_ENABLE, I_VALID, I_OPCODE, I_A, I_B,
    output O_READY, O_VALID, O_C, O_STATUS, O_BUSY
  );
endinterface

// File: rtl/cr16_alu_seq.sv
// Registered CR16 ALU with persistent {N,Z,F,L,C} status: 1-cycle ops, WIDTH+1-cycle shift-add MUL.
// O_READY drops while a multiply runs or I_ENABLE is low; a disabled cycle freezes everything, results are never lost.
module cr16_alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic             I_CLK,
  input logic             I_NRESET,
  cr16_alu_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LSH   = 4'd10;
  localparam logic [3:0] OP_ASH   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  localparam int SN = 4, SZ = 3, SF = 2, SL = 1, SC = 0;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [4:0]       st_q, st_d;
  logic             vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add, ovf_sub;
  logic             bneg, big;
  logic [WIDTH-1:0] bmag, shl, shr_l, shr_a, lsh_r, ash_r;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] a, b;

  assign a              = bus.I_A;
  assign b              = bus.I_B;
  assign bus.O_READY    = bus.I_ENABLE && (state_q == S_IDLE);
  assign accept         = bus.I_VALID && bus.O_READY;
  assign bus.O_VALID    = vld_q;
  assign bus.O_C        = c_q;
  assign bus.O_STATUS   = st_q;
  assign bus.O_BUSY     = (state_q == S_MUL);

  // Shared WIDTH+1-bit datapath; bit WIDTH is the carry / borrow.
  always_comb begin
    cin     = ((bus.I_OPCODE == OP_ADDC) || (bus.I_OPCODE == OP_ADDCU)) ? st_q[SC] : 1'b0;
    sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff    = {1'b0, a} - {1'b0, b};
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    bneg    = b[WIDTH-1];
    bmag    = bneg ? (~b + 1'b1) : b;
    big     = (bmag >= WIDTH'(WIDTH));
    shl     = a << bmag;
    shr_l   = a >> bmag;
    shr_a   = $unsigned($signed(a) >>> bmag);
    lsh_r   = big ? '0 : (bneg ? shr_l : shl);
    ash_r   = big ? '0 : (bneg ? shr_a : shl);
    acc_nx  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    st_d     = st_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;

    if (bus.I_ENABLE) begin
      vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            vld_d = 1'b1;
            case (bus.I_OPCODE)
              OP_ADD, OP_ADDC: begin
                c_d      = sum[WIDTH-1:0];
                st_d[SF] = ovf_add;
                st_d[SZ] = (sum[WIDTH-1:0] == '0);
                st_d[SN] = sum[WIDTH-1];
              end
              OP_ADDU, OP_ADDCU: begin
                c_d      = sum[WIDTH-1:0];
                st_d[SC] = sum[WIDTH];
                st_d[SZ] = (sum[WIDTH-1:0] == '0);
              end
              OP_SUB: begin
                c_d      = diff[WIDTH-1:0];
                st_d[SF] = ovf_sub;
                st_d[SZ] = (diff[WIDTH-1:0] == '0);
                st_d[SN] = diff[WIDTH-1];
              end
              OP_CMP: begin
                st_d[SZ] = (a == b);
                st_d[SL] = diff[WIDTH];
                st_d[SN] = ($signed(a) < $signed(b));
              end
              OP_AND: begin c_d = a & b; st_d[SZ] = ((a & b) == '0); end
              OP_OR:  begin c_d = a | b; st_d[SZ] = ((a | b) == '0); end
              OP_XOR: begin c_d = a ^ b; st_d[SZ] = ((a ^ b) == '0); end
              OP_NOT: begin c_d = ~a;    st_d[SZ] = (~a == '0);      end
              OP_LSH: begin c_d = lsh_r; st_d[SZ] = (lsh_r == '0);   end
              OP_ASH: begin
                c_d      = ash_r;
                st_d[SZ] = (ash_r == '0);
                st_d[SN] = ash_r[WIDTH-1];
              end
              OP_MUL: begin
                if (MUL_EN) begin
                  vld_d    = 1'b0;
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = a;
                  mplier_d = b;
                end else begin
                  c_d = '0;
                end
              end
              default: c_d = '0;
            endcase
          end
        end
        S_MUL: begin
          // One multiplier bit per enabled cycle; the last step writes the result directly.
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            c_d      = acc_nx;
            st_d[SZ] = (acc_nx == '0);
            vld_d    = 1'b1;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      st_q     <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      st_q     <= st_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
